instr_sequencer: RTL and testbench
==================================

Name: instr_sequencer

Overview:
- Multi-cycle fetch/decode/execute controller for the 16-bit, 32-entry instruction store.
- Owns the program counter and drives the instruction memory address.
- Latches each instruction word and sequences the register file, ALU and main memory (MM) through per-instruction-class state paths.
- Sits between the instruction ROM and the datapath top level.

Parameters:
ADDR_W, 5, program counter / instruction address width
INSTR_W, 16, instruction width; fields are ctrl[15:12], A[11:8], B[7:4], C/offset[3:0]
START_ADDR, 0, PC value after reset

Ports:
clk  input  1  system clock; all state changes on the rising edge
rst_n  input  1  asynchronous, active-low reset
run  input  1  level; 1 = execute, 0 = stop at the next instruction boundary
imem_addr  output  5  registered PC, to instruction memory
imem_ins  input  16  instruction word, combinational from imem_addr
cmp_eq  input  1  datapath flag: R[A]==R[B], valid in EXEC
rf_rd_a  output  4  register read port A address
rf_rd_b  output  4  register read port B address
rf_wr_addr  output  4  register write address
rf_wr_en  output  1  register write strobe
wb_sel  output  1  writeback source: 0 = ALU, 1 = MM read data
alu_op  output  2  00 = ADD, 01 = SUB, 10 = SLT (A<B ? 1 : 0), 11 = unused
mm_addr  output  4  main memory address
mm_rd_en  output  1  MM read strobe; data valid the cycle after
mm_wr_en  output  1  MM write strobe; write data = R[B]
busy  output  1  1 whenever the state is not IDLE
illegal  output  1  one-cycle pulse on an undefined opcode

Behaviour:
- Reset (async, rst_n=0): state=IDLE, PC=START_ADDR, IR=0, all strobes 0, alu_op=00, wb_sel=0, all address outputs 0. Takes effect mid-instruction with no partial writes after assertion.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB.
- IDLE: if run=1, go to FETCH. A stop does not reset the PC; restart resumes at the PC.
- FETCH: imem_addr=PC; IR<=imem_ins at the clock edge; go to DECODE.
- DECODE: rf_rd_a=IR[11:8], rf_rd_b=IR[7:4]; alu_op decoded; go to EXEC.
- EXEC, by opcode:
  - 0010 ADD, 0110 SUB, 0111 SLT: alu_op valid, PC<=PC+1, go to WB.
  - 1000 LOAD: mm_addr=IR[3:0], mm_rd_en=1, PC<=PC+1, go to MEM.
  - 1010 STORE: mm_addr=IR[3:0], mm_wr_en=1, rf_rd_b=IR[7:4], PC<=PC+1, go to MEM.
  - 1110 BNE: if cmp_eq=0, PC<=PC+1+sext(IR[3:0]); otherwise PC<=PC+1. Go to FETCH/IDLE.
  - 1111 JMP: PC<=IR[4:0]; go to FETCH/IDLE.
  - 0000 NOP: PC<=PC+1; go to FETCH/IDLE.
  - Any other opcode: treated as NOP plus an illegal pulse.
- MEM: LOAD goes to WB with mm_addr held; STORE goes to FETCH/IDLE.
- WB: rf_wr_en=1 for one cycle.
  - ALU ops: rf_wr_addr=IR[3:0], wb_sel=0.
  - LOAD: rf_wr_addr=IR[7:4], wb_sel=1.
  - Then go to FETCH/IDLE.
- "FETCH/IDLE" means FETCH if run=1, otherwise IDLE; run is sampled only at the instruction boundary.
- Latency in cycles: BNE/JMP/NOP 3; ALU 4; STORE 4; LOAD 5.
- Strobes are one cycle wide; at most one of rf_wr_en, mm_rd_en, mm_wr_en is high in any cycle.
- PC arithmetic is modulo 32: 31+1 = 0; branch offset is 4-bit two's complement (-8..+7).
- PC changes only in EXEC; imem_addr is stable in all other states.

Test Plan:
1. Reset/idle: assert rst_n=0 mid-EXEC -> all strobes 0, imem_addr=0, busy=0 immediately; release with run=0 -> stays IDLE, busy=0.
2. ALU and load timing: run=1 on word 0 (1000_1111_0000_1110) -> mm_rd_en high with mm_addr=14 in cycle 3; rf_wr_en high with rf_wr_addr=0, wb_sel=1 in cycle 5; next FETCH at imem_addr=1. ADD 0010_0001_0010_0001 -> rf_wr_en with rf_wr_addr=1, alu_op=00 in its cycle 4.
3. BNE at PC=7 (1110_0011_0000_1101): cmp_eq=0 -> next imem_addr=5; cmp_eq=1 -> next imem_addr=8. Instruction takes 3 cycles with no strobes.
4. JMP chain: PC=11 (1111_0000_0001_1111) -> 31; word 31 (JMP 16) -> 16. Wrap check: BNE at PC=31 with offset +1 and cmp_eq=0 -> PC=1.
5. Stop/resume: drop run mid-LOAD -> LOAD completes including writeback, then IDLE with PC=next; raise run -> fetch resumes at that PC. Opcode 0100 -> illegal pulses once, PC+1.

Source files
------------

// File: rtl/instr_sequencer_if.sv
// instr_sequencer_if: sequencer <-> ROM/datapath bundle.
// master = sequencer side, slave = ROM/datapath side.
interface instr_sequencer_if #(
  parameter int ADDR_W  = 5,
  parameter int INSTR_W = 16
);
  logic               run;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_ins;
  logic               cmp_eq;
  logic [3:0]         rf_rd_a;
  logic [3:0]         rf_rd_b;
  logic [3:0]         rf_wr_addr;
  logic               rf_wr_en;
  logic               wb_sel;
  logic [1:0]         alu_op;
  logic [3:0]         mm_addr;
  logic               mm_rd_en;
  logic               mm_wr_en;
  logic               busy;
  logic               illegal;

  modport master (
    input  run, imem_ins, cmp_eq,
    output imem_addr, rf_rd_a, rf_rd_b,
    output rf_wr_addr, rf_wr_en, wb_sel,
    output alu_op, mm_addr, mm_rd_en,
    output mm_wr_en, busy, illegal
  );

  modport slave (
    output run, imem_ins, cmp_eq,
    input  imem_addr, rf_rd_a, rf_rd_b,
    input  rf_wr_addr, rf_wr_en, wb_sel,
    input  alu_op, mm_addr, mm_rd_en,
    input  mm_wr_en, busy, illegal
  );
endinterface

// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle fetch/decode/execute controller.
// Ports: clk, rst_n (async low), bus (instr_sequencer_if.master).
module instr_sequencer #(
  parameter int ADDR_W     = 5,
  parameter int INSTR_W    = 16,
  parameter int START_ADDR = 0
) (
  input logic                clk,
  input logic                rst_n,
  instr_sequencer_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ADDR_W-1:0]  r_pc;
  logic [ADDR_W-1:0]  w_pc_nxt;
  logic [INSTR_W-1:0] r_ir;
  logic [INSTR_W-1:0] w_ir_nxt;

  logic [3:0]         w_op;
  logic               w_is_alu;
  logic               w_is_ld;
  logic               w_is_st;
  logic               w_is_bne;
  logic               w_is_jmp;
  logic               w_is_nop;
  logic [1:0]         w_alu_op;
  logic [ADDR_W-1:0]  w_pc_inc;
  logic [ADDR_W-1:0]  w_off;
  state_t             w_bnd;

  assign w_op     = r_ir[15:12];
  assign w_is_alu = (w_op == 4'b0010) ||
                    (w_op == 4'b0110) ||
                    (w_op == 4'b0111);
  assign w_is_ld  = (w_op == 4'b1000);
  assign w_is_st  = (w_op == 4'b1010);
  assign w_is_bne = (w_op == 4'b1110);
  assign w_is_jmp = (w_op == 4'b1111);
  assign w_is_nop = (w_op == 4'b0000);

  always_comb begin
    w_alu_op = 2'b00;
    unique case (1'b1)
      (w_op == 4'b0110): w_alu_op = 2'b01;
      (w_op == 4'b0111): w_alu_op = 2'b10;
      default:           w_alu_op = 2'b00;
    endcase
  end

  // PC arithmetic wraps at the address width.
  assign w_pc_inc = r_pc + ADDR_W'(1);
  assign w_off    = {{(ADDR_W-4){r_ir[3]}}, r_ir[3:0]};
  // run is looked at only when an instruction retires.
  assign w_bnd    = bus.run ? S_FETCH : S_IDLE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_pc    <= ADDR_W'(START_ADDR);
      r_ir    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_ir    <= w_ir_nxt;
    end
  end

  assign bus.imem_addr = r_pc;
  assign bus.busy      = (r_state != S_IDLE);

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_ir_nxt       = r_ir;
    bus.rf_rd_a    = 4'd0;
    bus.rf_rd_b    = 4'd0;
    bus.rf_wr_addr = 4'd0;
    bus.rf_wr_en   = 1'b0;
    bus.wb_sel     = 1'b0;
    bus.alu_op     = 2'b00;
    bus.mm_addr    = 4'd0;
    bus.mm_rd_en   = 1'b0;
    bus.mm_wr_en   = 1'b0;
    bus.illegal    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.run) w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        w_ir_nxt    = bus.imem_ins;
        w_state_nxt = S_DECODE;
      end
      S_DECODE: begin
        bus.rf_rd_a = r_ir[11:8];
        bus.rf_rd_b = r_ir[7:4];
        bus.alu_op  = w_alu_op;
        w_state_nxt = S_EXEC;
      end
      S_EXEC: begin
        bus.rf_rd_a = r_ir[11:8];
        bus.rf_rd_b = r_ir[7:4];
        bus.alu_op  = w_alu_op;
        unique case (1'b1)
          w_is_alu: begin
            w_pc_nxt    = w_pc_inc;
            w_state_nxt = S_WB;
          end
          w_is_ld: begin
            bus.mm_addr  = r_ir[3:0];
            bus.mm_rd_en = 1'b1;
            w_pc_nxt     = w_pc_inc;
            w_state_nxt  = S_MEM;
          end
          w_is_st: begin
            bus.mm_addr  = r_ir[3:0];
            bus.mm_wr_en = 1'b1;
            w_pc_nxt     = w_pc_inc;
            w_state_nxt  = S_MEM;
          end
          w_is_bne: begin
            w_pc_nxt    = bus.cmp_eq ? w_pc_inc
                                     : w_pc_inc + w_off;
            w_state_nxt = w_bnd;
          end
          w_is_jmp: begin
            w_pc_nxt    = r_ir[ADDR_W-1:0];
            w_state_nxt = w_bnd;
          end
          default: begin
            // Undefined opcodes retire as NOP.
            bus.illegal = !w_is_nop;
            w_pc_nxt    = w_pc_inc;
            w_state_nxt = w_bnd;
          end
        endcase
      end
      S_MEM: begin
        bus.rf_rd_a = r_ir[11:8];
        bus.rf_rd_b = r_ir[7:4];
        if (w_is_ld) begin
          bus.mm_addr = r_ir[3:0];
          w_state_nxt = S_WB;
        end else begin
          w_state_nxt = w_bnd;
        end
      end
      S_WB: begin
        bus.rf_rd_a  = r_ir[11:8];
        bus.rf_rd_b  = r_ir[7:4];
        bus.alu_op   = w_alu_op;
        bus.rf_wr_en = 1'b1;
        if (w_is_ld) begin
          bus.rf_wr_addr = r_ir[7:4];
          bus.wb_sel     = 1'b1;
        end else begin
          bus.rf_wr_addr = r_ir[3:0];
        end
        w_state_nxt = w_bnd;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: directed scoreboard bench.
// Strobe events are queued at issue and popped as they appear.
module tb_instr_sequencer;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic run   = 1'b0;
  logic cmp   = 1'b0;
  logic [15:0] mem [32];
  int cyc    = 0;
  int n_chk  = 0;
  int n_fail = 0;
  logic [4:0] pc_m = 5'd0;

  typedef struct packed {
    logic [1:0]  kind;
    logic [15:0] cyc;
    logic [3:0]  addr;
    logic        wb;
    logic [1:0]  alu;
  } ev_t;

  localparam logic [1:0] K_WR = 2'd0;
  localparam logic [1:0] K_RD = 2'd1;
  localparam logic [1:0] K_MW = 2'd2;
  localparam logic [1:0] K_IL = 2'd3;

  ev_t q[$];

  instr_sequencer_if bus ();

  assign bus.run      = run;
  assign bus.cmp_eq   = cmp;
  assign bus.imem_ins = mem[bus.imem_addr];

  instr_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // Strobe monitor against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      int   n;
      ev_t  o;
      n = int'(bus.rf_wr_en) + int'(bus.mm_rd_en) +
          int'(bus.mm_wr_en) + int'(bus.illegal);
      chk("strobe_onehot", 32'(n <= 1), 32'd1);
      if (n != 0) begin
        o = '0;
        o.cyc = 16'(cyc);
        if (bus.rf_wr_en) begin
          o.kind = K_WR;
          o.addr = bus.rf_wr_addr;
          o.wb   = bus.wb_sel;
          o.alu  = bus.wb_sel ? 2'b00 : bus.alu_op;
        end else if (bus.mm_rd_en) begin
          o.kind = K_RD;
          o.addr = bus.mm_addr;
        end else if (bus.mm_wr_en) begin
          o.kind = K_MW;
          o.addr = bus.mm_addr;
        end else begin
          o.kind = K_IL;
        end
        if (q.size() == 0) begin
          chk("unexpected_strobe", 32'(o), 32'd0);
        end else begin
          chk("strobe_event", 32'(o), 32'(q.pop_front()));
        end
      end
    end
  end

  function automatic logic [1:0] alu_of(input logic [3:0] op);
    case (op)
      4'b0110: return 2'b01;
      4'b0111: return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  // Reference: issue the instruction at pc_m, queue its strobes,
  // wait out its latency, advance pc_m.
  task automatic do_ins(input logic c, input bit drop_run);
    logic [15:0] ins;
    logic [3:0]  op;
    logic [4:0]  npc;
    int          c0;
    int          lat;
    ins = mem[pc_m];
    op  = ins[15:12];
    chk("fetch_pc", {26'd0, bus.busy, bus.imem_addr},
        {26'd0, 1'b1, pc_m});
    c0  = cyc;
    cmp = c;
    npc = pc_m + 5'd1;
    lat = 3;
    case (op)
      4'b0010, 4'b0110, 4'b0111: begin
        lat = 4;
        q.push_back('{K_WR, 16'(c0 + 3), ins[3:0],
                      1'b0, alu_of(op)});
      end
      4'b1000: begin
        lat = 5;
        q.push_back('{K_RD, 16'(c0 + 2), ins[3:0],
                      1'b0, 2'b00});
        q.push_back('{K_WR, 16'(c0 + 4), ins[7:4],
                      1'b1, 2'b00});
      end
      4'b1010: begin
        lat = 4;
        q.push_back('{K_MW, 16'(c0 + 2), ins[3:0],
                      1'b0, 2'b00});
      end
      4'b1110: begin
        if (!c) npc = pc_m + 5'd1 + {ins[3], ins[3:0]};
      end
      4'b1111: npc = ins[4:0];
      4'b0000: ;
      default: begin
        q.push_back('{K_IL, 16'(c0 + 2), 4'd0,
                      1'b0, 2'b00});
      end
    endcase
    @(negedge clk);
    if (drop_run) run = 1'b0;
    repeat (lat - 1) @(negedge clk);
    pc_m = npc;
  endtask

  initial begin
    foreach (mem[i]) mem[i] = 16'h0000;
    mem[0]  = 16'h8F0E;
    mem[1]  = 16'h2121;
    mem[2]  = 16'h6345;
    mem[3]  = 16'h7236;
    mem[4]  = 16'hA027;
    mem[7]  = 16'hE30D;
    mem[8]  = 16'h4000;
    mem[11] = 16'hF01F;
    mem[31] = 16'hF010;
    mem[16] = 16'h8F23;

    #12;
    chk("reset_outputs",
        {3'd0, bus.busy, bus.imem_addr, bus.rf_rd_a,
         bus.rf_rd_b, bus.rf_wr_addr, bus.rf_wr_en,
         bus.wb_sel, bus.alu_op, bus.mm_addr,
         bus.mm_rd_en, bus.mm_wr_en, bus.illegal},
        32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_run0", {26'd0, bus.busy, bus.imem_addr},
          32'd0);
    end

    run = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 7; i++) do_ins(1'b0, 1'b0);
    do_ins(1'b0, 1'b0);
    do_ins(1'b0, 1'b0);
    do_ins(1'b0, 1'b0);
    do_ins(1'b1, 1'b0);
    do_ins(1'b0, 1'b0);
    do_ins(1'b0, 1'b0);
    do_ins(1'b0, 1'b0);
    do_ins(1'b0, 1'b0);
    do_ins(1'b0, 1'b0);
    do_ins(1'b0, 1'b1);

    repeat (3) begin
      chk("stopped_idle", {26'd0, bus.busy, bus.imem_addr},
          {26'd0, 1'b0, pc_m});
      @(negedge clk);
    end

    mem[17] = 16'hF01F;
    mem[31] = 16'hE001;
    run = 1'b1;
    @(negedge clk);
    do_ins(1'b0, 1'b0);
    do_ins(1'b0, 1'b0);
    do_ins(1'b0, 1'b0);

    chk("fetch_pc", {26'd0, bus.busy, bus.imem_addr},
        {26'd0, 1'b1, pc_m});
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_mid_exec",
        {3'd0, bus.busy, bus.imem_addr, bus.rf_rd_a,
         bus.rf_rd_b, bus.rf_wr_addr, bus.rf_wr_en,
         bus.wb_sel, bus.alu_op, bus.mm_addr,
         bus.mm_rd_en, bus.mm_wr_en, bus.illegal},
        32'd0);
    run = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("idle_after_reset",
          {26'd0, bus.busy, bus.imem_addr}, 32'd0);
    end

    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
